// File: rtl/gba_rom_bus.sv
// GBA cartridge ROM bus sequencer: SEEK/READ commands become
// CS/RD bus cycles with sequential burst reads.
// Ports: CLK, RST_N; cmd_seek/seek_addr/cmd_read in;
//   busy, data_valid, data_out out;
//   CS, RD, WR, A_HI, AD_oe, AD_out out; AD_in in.
module gba_rom_bus #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_seek,
  input  logic [23:0] seek_addr,
  input  logic        cmd_read,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic        CS,
  output logic        RD,
  output logic        WR,
  output logic [7:0]  A_HI,
  output logic        AD_oe,
  output logic [15:0] AD_out,
  input  logic [15:0] AD_in
);

  localparam int unsigned MAXC01 =
    (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
  localparam int unsigned MAXC =
    (MAXC01 > HOLD_CYCLES) ? MAXC01 : HOLD_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t S_LD = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t A_LD = cnt_t'(ACCESS_CYCLES - 1);
  localparam cnt_t H_LD = cnt_t'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, LATCH, TURN, STROBE, RECOVER
  } state_t;

  state_t      state_q;
  cnt_t        cnt_q;
  logic [23:0] addr_q;
  logic        open_q;

  logic [23:0] addr_inc;
  logic [23:0] rd_addr;

  assign addr_inc = addr_q + 24'd1;
  // A same-cycle seek wins, so the read starts from seek_addr
  assign rd_addr  = cmd_seek ? seek_addr : addr_q;
  assign WR       = 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      open_q     <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      CS         <= 1'b1;
      RD         <= 1'b1;
      A_HI       <= '0;
      AD_oe      <= 1'b0;
      AD_out     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_seek) begin
            addr_q <= seek_addr;
            open_q <= 1'b0;
            CS     <= 1'b1;
          end
          if (cmd_read) begin
            busy <= 1'b1;
            if (open_q && !cmd_seek) begin
              state_q <= STROBE;
              cnt_q   <= A_LD;
              RD      <= 1'b0;
            end else begin
              state_q <= ADDR;
              cnt_q   <= S_LD;
              CS      <= 1'b1;
              AD_oe   <= 1'b1;
              AD_out  <= rd_addr[15:0];
              A_HI    <= rd_addr[23:16];
            end
          end
        end
        ADDR: begin
          if (cnt_q == '0) begin
            state_q <= LATCH;
            CS      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        LATCH: begin
          state_q <= TURN;
          AD_oe   <= 1'b0;
          AD_out  <= '0;
          A_HI    <= '0;
        end
        TURN: begin
          state_q <= STROBE;
          cnt_q   <= A_LD;
          RD      <= 1'b0;
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q    <= RECOVER;
            cnt_q      <= H_LD;
            RD         <= 1'b1;
            data_out   <= AD_in;
            data_valid <= 1'b1;
            addr_q     <= addr_inc;
            // Cartridge counter only spans 16 bits: close on wrap
            open_q     <= |addr_inc[15:0];
            if (addr_inc[15:0] == 16'h0000) CS <= 1'b1;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        RECOVER: begin
          data_valid <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_rom_bus.sv
// Testbench for gba_rom_bus: cartridge model, directed
// vector table, hand sequences and a randomized model check.
module tb_gba_rom_bus;

  localparam int S = 2;
  localparam int A = 4;
  localparam int H = 1;
  // edges after the accepting edge until data_valid is seen
  localparam int LC = S + A + 2;
  localparam int LO = A;

  logic        CLK;
  logic        RST_N;
  logic        cmd_seek;
  logic [23:0] seek_addr;
  logic        cmd_read;
  logic        busy;
  logic        data_valid;
  logic [15:0] data_out;
  logic        CS;
  logic        RD;
  logic        WR;
  logic [7:0]  A_HI;
  logic        AD_oe;
  logic [15:0] AD_out;
  logic [15:0] AD_in;

  gba_rom_bus #(
    .SETUP_CYCLES(S),
    .ACCESS_CYCLES(A),
    .HOLD_CYCLES(H)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .cmd_seek(cmd_seek),
    .seek_addr(seek_addr),
    .cmd_read(cmd_read),
    .busy(busy),
    .data_valid(data_valid),
    .data_out(data_out),
    .CS(CS),
    .RD(RD),
    .WR(WR),
    .A_HI(A_HI),
    .AD_oe(AD_oe),
    .AD_out(AD_out),
    .AD_in(AD_in)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic logic [15:0] rom(input logic [23:0] a);
    return 16'h2E00 ^ (a[15:0] * 16'd3) ^ {a[23:16], a[23:16]};
  endfunction

  // cartridge: latch on CS fall, 16-bit counter bumps on RD rise
  logic [23:0] cart_addr = '0;
  logic [23:0] latch_addr = '0;
  int          latch_cnt = 0;
  int          mon_bad = 0;

  assign AD_in = rom(cart_addr);

  always @(negedge CS) begin
    if (RST_N === 1'b1) begin
      cart_addr  = {A_HI, AD_out};
      latch_addr = {A_HI, AD_out};
      latch_cnt++;
    end
  end

  always @(posedge RD) begin
    if (RST_N === 1'b1 && CS === 1'b0)
      cart_addr[15:0] = cart_addr[15:0] + 16'd1;
  end

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && AD_oe === 1'b1 && RD === 1'b0)
      mon_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic op(input bit sk, input logic [23:0] sa,
                    input bit rd, output int lat,
                    output logic [15:0] d, output int rdl,
                    output logic cs1);
    cmd_seek  = sk;
    seek_addr = sa;
    cmd_read  = rd;
    @(posedge CLK); #1;
    cmd_seek = 1'b0;
    cmd_read = 1'b0;
    cs1 = CS;
    lat = -1;
    d   = 16'hxxxx;
    rdl = 0;
    if (rd) begin
      for (int n = 0; n < 64; n++) begin
        if (data_valid) begin
          lat = n;
          d   = data_out;
          break;
        end
        if (RD === 1'b0) rdl++;
        @(posedge CLK); #1;
      end
      for (int n = 0; n < 16 && busy; n++) begin
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic run(input string tag, input bit sk,
                     input logic [23:0] sa, input bit rd,
                     input int elat, input logic [15:0] edata,
                     input bit closed, input logic [23:0] elatch,
                     input bit ecs1, input bit ecs_end);
    int          lat;
    int          rdl;
    logic [15:0] d;
    logic        cs1;
    int          lc0;
    lc0 = latch_cnt;
    op(sk, sa, rd, lat, d, rdl, cs1);
    chk({tag, " cs_k1"}, 32'(cs1), 32'(ecs1));
    if (rd) begin
      chk({tag, " latency"}, lat, elat);
      chk({tag, " data"}, 32'(d), 32'(edata));
      chk({tag, " rd_low"}, rdl, A);
      chk({tag, " busy_end"}, 32'(busy), 32'd0);
      chk({tag, " latches"}, latch_cnt - lc0, closed ? 1 : 0);
      if (closed)
        chk({tag, " latch_addr"}, 32'(latch_addr), 32'(elatch));
      chk({tag, " ad_idle"}, {8'h0, A_HI, AD_out, 7'h0, AD_oe},
          32'd0);
    end
    chk({tag, " cs_end"}, 32'(CS), 32'(ecs_end));
  endtask

  typedef struct {
    bit          sk;
    logic [23:0] sa;
    bit          rd;
    int          lat;
    logic [15:0] data;
    bit          closed;
    logic [23:0] latch;
    bit          cs1;
    bit          cs_end;
  } vec_t;

  vec_t tbl[8];

  logic [23:0] am;
  bit          om;

  initial begin
    tbl[0] = '{1, 24'h000000, 0, 0,  16'h0,          0, 24'h0,      1, 1};
    tbl[1] = '{0, 24'h000000, 1, LC, 16'h2E00,       1, 24'h000000, 1, 0};
    tbl[2] = '{0, 24'h000000, 1, LO, rom(24'h000001), 0, 24'h0,     0, 0};
    tbl[3] = '{0, 24'h000000, 1, LO, rom(24'h000002), 0, 24'h0,     0, 0};
    tbl[4] = '{1, 24'h01FFFF, 0, 0,  16'h0,          0, 24'h0,      1, 1};
    tbl[5] = '{0, 24'h000000, 1, LC, rom(24'h01FFFF), 1, 24'h01FFFF, 1, 1};
    tbl[6] = '{0, 24'h000000, 1, LC, rom(24'h020000), 1, 24'h020000, 1, 0};
    tbl[7] = '{1, 24'h000100, 1, LC, rom(24'h000100), 1, 24'h000100, 1, 0};

    RST_N     = 1'b0;
    cmd_seek  = 1'b0;
    cmd_read  = 1'b0;
    seek_addr = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset CS", 32'(CS), 32'd1);
    chk("reset RD", 32'(RD), 32'd1);
    chk("reset WR", 32'(WR), 32'd1);
    chk("reset bus", {8'h0, A_HI, AD_out, 7'h0, AD_oe}, 32'd0);
    chk("reset busy/dv", {30'h0, busy, data_valid}, 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++)
      run($sformatf("vec%0d", i), tbl[i].sk, tbl[i].sa, tbl[i].rd,
          tbl[i].lat, tbl[i].data, tbl[i].closed, tbl[i].latch,
          tbl[i].cs1, tbl[i].cs_end);

    // commands while busy are dropped
    begin
      int dv;
      run("busy seek", 1, 24'h000010, 0, 0, 16'h0, 0, 24'h0, 1, 1);
      cmd_read = 1'b1;
      @(posedge CLK); #1;
      dv = 0;
      for (int n = 0; n < 20; n++) begin
        if (n < 6) begin
          cmd_read  = 1'b1;
          cmd_seek  = 1'b1;
          seek_addr = 24'hABCDEF;
        end else begin
          cmd_read = 1'b0;
          cmd_seek = 1'b0;
        end
        @(posedge CLK); #1;
        if (data_valid) dv++;
      end
      chk("busy dv_count", dv, 1);
      chk("busy data", 32'(data_out), 32'(rom(24'h000010)));
      run("busy next", 0, 24'h0, 1, LO, rom(24'h000011), 0,
          24'h0, 0, 0);
    end

    // asynchronous reset in the middle of a strobe
    begin
      run("rst seek", 1, 24'h000040, 0, 0, 16'h0, 0, 24'h0, 1, 1);
      cmd_read = 1'b1;
      @(posedge CLK); #1;
      cmd_read = 1'b0;
      for (int n = 0; n < 20 && RD; n++) begin
        @(posedge CLK); #1;
      end
      chk("rst in strobe", 32'(RD), 32'd0);
      #2;
      RST_N = 1'b0;
      #1;
      chk("rst async CS", 32'(CS), 32'd1);
      chk("rst async RD", 32'(RD), 32'd1);
      chk("rst async oe", 32'(AD_oe), 32'd0);
      chk("rst async busy", 32'(busy), 32'd0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      run("rst after", 0, 24'h0, 1, LC, rom(24'h000000), 1,
          24'h000000, 1, 0);
    end

    // randomized ops against a behavioural address/burst model
    am = 24'h000001;
    om = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int          kind;
      bit          sk;
      bit          rd;
      logic [23:0] sa;
      int          elat;
      logic [15:0] ed;
      bit          closed;
      bit          ecs1;
      kind = $urandom_range(0, 3);
      sk = (kind == 0 || kind == 3);
      rd = (kind != 0);
      sa = 24'($urandom);
      if ($urandom_range(0, 1) == 1)
        sa[15:0] = 16'hFFFF - 16'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) sa = 24'hFFFFFF;
      if (sk) begin
        am = sa;
        om = 1'b0;
      end
      ecs1   = !om;
      closed = !om;
      elat   = om ? LO : LC;
      ed     = rom(am);
      if (rd) begin
        am = am + 24'd1;
        om = (am[15:0] != 16'h0000);
      end
      run($sformatf("rnd%0d", i), sk, sa, rd, elat, ed, closed,
          sk ? sa : am - 24'd1, rd ? ecs1 : 1'b1, !om);
    end

    chk("oe during RD low", mon_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/gba_rom_bus.md
# gba_rom_bus

Cartridge-side bus sequencer for the GBA ROM reader on the TinyFPGA BX. Sits directly downstream of the SPI command decoder in `top`. It turns SEEK/READ commands into GBA ROM bus cycles: address latch on CS fall, RD strobes, sequential burst reads. It returns each 16-bit halfword to the decoder. The AD pads stay in the `SB_IO` array in `top`; this block drives the pads' output-enable/output and samples their input.

## Interface

Parameters:
- `SETUP_CYCLES`, 2: cycles AD/A_HI are driven with CS high before CS falls (≥1)
- `ACCESS_CYCLES`, 4: cycles RD is held low per halfword (≥1)
- `HOLD_CYCLES`, 1: cycles RD is held high after each strobe before the next command (≥1)

Ports:
- `CLK`  in  1  16 MHz system clock; all logic on rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `cmd_seek`  in  1  one-cycle pulse: load `seek_addr`
- `seek_addr`  in  24  halfword address (byte address >> 1)
- `cmd_read`  in  1  one-cycle pulse: read one halfword at the current address
- `busy`  out  1  high while a read is in progress; commands ignored
- `data_valid`  out  1  one-cycle pulse: `data_out` holds a new halfword
- `data_out`  out  16  last halfword read
- `CS`  out  1  cartridge chip select, active-low
- `RD`  out  1  cartridge read strobe, active-low
- `WR`  out  1  cartridge write strobe; constant 1
- `A_HI`  out  8  address bits 23:16
- `AD_oe`  out  1  AD pad output enable
- `AD_out`  out  16  AD pad output value (address bits 15:0)
- `AD_in`  in  16  AD pad input value

## Operation

- Registers:
  - `addr[23:0]`: current halfword address.
  - `open`: burst open, meaning the cartridge has latched `addr` and CS is low.
- Reset values: `CS`=1, `RD`=1, `WR`=1, `AD_oe`=0, `AD_out`=0, `A_HI`=0, `busy`=0, `data_valid`=0, `data_out`=0, `addr`=0, `open`=0, state IDLE.
- States:
  - IDLE: `busy`=0. Accepts commands.
  - ADDR: `CS`=1, `AD_oe`=1, `AD_out`=`addr[15:0]`, `A_HI`=`addr[23:16]`. Lasts `SETUP_CYCLES`.
  - LATCH: `CS`=0, AD still driven. 1 cycle.
  - TURN: `AD_oe`=0. 1 cycle.
  - STROBE: `RD`=0. Lasts `ACCESS_CYCLES`. On the edge ending the last STROBE cycle, `data_out`<=`AD_in`.
  - RECOVER: `RD`=1. Lasts `HOLD_CYCLES`. `data_valid`=1 in its first cycle only. Returns to IDLE.
- IDLE, `cmd_seek`=1:
  - `addr`<=`seek_addr`, `open`<=0, `CS`<=1.
  - No `busy`.
- IDLE, `cmd_read`=1 (and no seek):
  - `open`=0 → ADDR.
  - `open`=1 → STROBE directly. CS stays low.
- Simultaneous `cmd_seek` and `cmd_read` in IDLE:
  - Seek applied first.
  - Read proceeds from `seek_addr` via ADDR, with the burst treated as closed.
- After each STROBE:
  - `addr`<=`addr`+1, modulo 2^24.
  - `open`<=1, unless the new `addr[15:0]`==0. The cartridge counter does not carry into A_HI, so on that wrap set `open`<=0 and `CS`<=1 at entry to RECOVER.
- Commands arriving while `busy`=1 are dropped. No queuing.
- `AD_oe` is never high while `RD`=0.
- `AD_out` and `A_HI` return to 0 when leaving LATCH.

## Timing

- Command accepted on edge k (state IDLE).
- Closed burst:
  - ADDR cycles k+1..k+S.
  - LATCH k+S+1.
  - TURN k+S+2.
  - STROBE k+S+3..k+S+A+2.
  - `data_valid` at k+S+A+3. Defaults: k+9.
- Open burst:
  - STROBE k+1..k+A.
  - `data_valid` at k+A+1. Defaults: k+5.
- `busy` is high from k+1 through the last RECOVER cycle. The next command is accepted in the first IDLE cycle after.
- Seek: `CS` high and `addr` updated at k+1.
- Reset mid-operation: outputs take reset values immediately and asynchronously (CS/RD high, AD released). State returns to IDLE with `open`=0.

## Test plan

- Reset, seek 0x000000, read with cartridge model returning 0x2E00 → `CS` falls at k+3. `RD` is low k+5..k+8. `data_valid` at k+9 with `data_out`=0x2E00. `AD_oe`=0 throughout STROBE.
- Two more reads → no new ADDR/LATCH and CS stays low. Each `data_valid` comes 5 cycles after its command. Data matches model addresses 1 and 2.
- Seek 0x01FFFF, two reads → first read latches A_HI=0x01, AD=0xFFFF. CS rises after the first strobe. The second read re-latches A_HI=0x02, AD=0x0000.
- `cmd_seek`=1 with `seek_addr`=0x000100 and `cmd_read`=1 in the same cycle → CS high at k+1. ADDR drives 0x0100. Data equals model[0x100].
- `cmd_read` and `cmd_seek` pulsed while `busy` → ignored: `addr` unchanged, exactly one `data_valid`.
- `RST_N` low during STROBE → `CS`=1, `RD`=1, `AD_oe`=0 without a clock edge. The next read after release goes through ADDR.
